quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 126 ++++++++++++
 tb/tb_quad_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop synchronisers, optional per-input glitch filter
// (enabled by defining QDEC_FILTER_EN), step/updown pulse generation and a sticky error flag.
module quad_decoder #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic enc_a,
   input  logic enc_b,
   input  logic err_clr,
   output logic step,
   output logic updown,
   output logic err
);

   if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
      $error("quad_decoder: FILT_LEN must be in 1..15");
   end

   // Bit 1 carries phase A, bit 0 phase B throughout.
   logic [1:0] sync1_reg;
   logic [1:0] sync2_reg;
   logic [1:0] filt;
   logic [1:0] prev_reg;
   logic [1:0] init_cnt_reg;
   logic       init_done_reg;
   logic [1:0] idx_diff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg <= 2'b00;
         sync2_reg <= 2'b00;
      end else begin
         sync1_reg <= {enc_a, enc_b};
         sync2_reg <= sync1_reg;
      end
   end

   // Two cycles to fill the synchronisers, then one load cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         init_cnt_reg  <= 2'd0;
         init_done_reg <= 1'b0;
      end else if (!init_done_reg) begin
         if (init_cnt_reg == 2'd2) begin
            init_done_reg <= 1'b1;
         end else begin
            init_cnt_reg <= init_cnt_reg + 2'd1;
         end
      end
   end

`ifdef QDEC_FILTER_EN
   localparam int CW = $clog2(FILT_LEN + 1);

   for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic [CW-1:0] cnt_reg;
      logic          filt_reg;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
         end else if (!init_done_reg) begin
            cnt_reg <= '0;
            if (init_cnt_reg == 2'd2) begin
               filt_reg <= sync2_reg[gi];
            end
         end else if (sync2_reg[gi] == filt_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
            filt_reg <= sync2_reg[gi];
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end

      assign filt[gi] = filt_reg;
   end
`else
   assign filt = sync2_reg;
`endif

   // Position in the forward Gray cycle 00,01,11,10 -> 0,1,2,3.
   function automatic logic [1:0] gray_idx(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   assign idx_diff = gray_idx(filt) - gray_idx(prev_reg);

   // A change arriving while step is high is held one cycle so pulses never merge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_reg <= 2'b00;
         step     <= 1'b0;
         updown   <= 1'b1;
         err      <= 1'b0;
      end else if (!init_done_reg) begin
         step <= 1'b0;
         if (init_cnt_reg == 2'd2) begin
            prev_reg <= sync2_reg;
         end
      end else begin
         step <= 1'b0;
         if (err_clr) begin
            err <= 1'b0;
         end
         if (!step && (filt != prev_reg)) begin
            prev_reg <= filt;
            case (idx_diff)
               2'd1: begin
                  step   <= 1'b1;
                  updown <= 1'b1;
               end
               2'd3: begin
                  step   <= 1'b1;
                  updown <= 1'b0;
               end
               default: err <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with a run-length behavioural model checked every cycle.
module tb_quad_decoder;

   localparam int FILT = 3;
`ifdef QDEC_FILTER_EN
   localparam int LAT   = FILT + 3;
   localparam int F_EFF = FILT;
   localparam int GL2   = 0;
`else
   localparam int LAT   = 3;
   localparam int F_EFF = 1;
   localparam int GL2   = 2;
`endif
   // Output edge relative to the edge on which the model accepts a level.
   localparam int D = LAT - F_EFF;

   logic clk = 1'b0;
   logic rst, enc_a, enc_b, err_clr;
   logic step, updown, err;

   int n_chk  = 0;
   int n_fail = 0;
   int steps  = 0;

   quad_decoder #(.FILT_LEN(FILT)) dut (
      .clk     (clk),
      .rst     (rst),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .err_clr (err_clr),
      .step    (step),
      .updown  (updown),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int quad_kind(input logic [1:0] o, input logic [1:0] nw);
      logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
      int po = 0;
      int pn = 0;
      for (int i = 0; i < 4; i++) begin
         if (seq[i] == o)  po = i;
         if (seq[i] == nw) pn = i;
      end
      if (pn == (po + 1) % 4) return 1;
      if (po == (pn + 1) % 4) return 2;
      return 3;
   endfunction

   // Model: a pin level is accepted once it has been sampled F_EFF times in a row.
   int         n;
   logic       acc_a, acc_b, run_a, run_b;
   int         len_a, len_b;
   int         sched [0:4095];
   logic       m_upd, m_err;

   always @(posedge clk) begin
      logic       pa, pb, pc, chg, e_step;
      logic [1:0] old_pair;
      int         k;
      if (!rst) begin
         n = 0;
         for (int i = 0; i < 4096; i++) sched[i] = 0;
         m_upd = 1'b1;
         m_err = 1'b0;
         #1;
         chk("rst_step", step, 0);
         chk("rst_updown", updown, 1);
         chk("rst_err", err, 0);
      end else begin
         n++;
         pa = enc_a;
         pb = enc_b;
         pc = err_clr;
         if (n == 1) begin
            acc_a = pa; acc_b = pb; run_a = pa; run_b = pb;
            len_a = F_EFF; len_b = F_EFF;
         end else begin
            old_pair = {acc_a, acc_b};
            if (pa == run_a) len_a++; else begin run_a = pa; len_a = 1; end
            if (pb == run_b) len_b++; else begin run_b = pb; len_b = 1; end
            chg = 1'b0;
            if (run_a != acc_a && len_a == F_EFF) begin acc_a = run_a; chg = 1'b1; end
            if (run_b != acc_b && len_b == F_EFF) begin acc_b = run_b; chg = 1'b1; end
            if (chg && n + D < 4096) sched[n + D] = quad_kind(old_pair, {acc_a, acc_b});
         end
         k = (n < 4096) ? sched[n] : 0;
         e_step = (k == 1 || k == 2);
         if (k == 1) m_upd = 1'b1;
         if (k == 2) m_upd = 1'b0;
         if (k == 3) m_err = 1'b1;
         else if (pc && n > 3) m_err = 1'b0;
         #1;
         chk($sformatf("step@%0d", n), step, e_step);
         chk($sformatf("updown@%0d", n), updown, m_upd);
         chk($sformatf("err@%0d", n), err, m_err);
         if (step) steps++;
      end
   end

   // Drive a new pin pair and measure cycles until step appears.
   task automatic drive(input logic a, input logic b, input string nm);
      int got = -1;
      @(negedge clk);
      enc_a = a;
      enc_b = b;
      for (int k = 1; k <= LAT + 4; k++) begin
         @(posedge clk);
         #1;
         if (step && got < 0) got = k;
      end
      chk(nm, got, LAT);
      $display("drive %s: pins=%b%b latency=%0d", nm, a, b, got);
   endtask

   task automatic do_reset(input logic a, input logic b);
      @(negedge clk);
      rst = 1'b0;
      enc_a = a;
      enc_b = b;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      rst = 1'b0; enc_a = 1'b1; enc_b = 1'b1; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("init_no_step", steps, 0);
      chk("init_err", err, 0);
      chk("init_updown", updown, 1);
      drive(1'b0, 1'b1, "lat_init_back");
      chk("init_back_dir", updown, 0);

      do_reset(1'b0, 1'b0);
      s0 = steps;
      drive(1'b0, 1'b1, "lat_fwd1");
      drive(1'b1, 1'b1, "lat_fwd2");
      drive(1'b1, 1'b0, "lat_fwd3");
      drive(1'b0, 1'b0, "lat_fwd4");
      chk("fwd_steps", steps - s0, 4);
      chk("fwd_updown", updown, 1);

      s0 = steps;
      drive(1'b1, 1'b0, "lat_back1");
      drive(1'b1, 1'b1, "lat_back2");
      drive(1'b0, 1'b1, "lat_back3");
      chk("back_steps", steps - s0, 3);
      chk("back_updown", updown, 0);
      drive(1'b1, 1'b1, "lat_fwd_after");
      chk("fwd_after_updown", updown, 1);

      s0 = steps;
      @(negedge clk); enc_a = 1'b0;
      @(negedge clk);
      @(negedge clk); enc_a = 1'b1;
      repeat (12) @(negedge clk);
      chk("glitch2_steps", steps - s0, GL2);
      $display("glitch 2-cycle: steps=%0d", steps - s0);

      s0 = steps;
      @(negedge clk); enc_a = 1'b0;
      repeat (3) @(negedge clk);
      enc_a = 1'b1;
      repeat (14) @(negedge clk);
      chk("pulse3_steps", steps - s0, 2);
      chk("pulse3_updown", updown, 1);
      $display("pulse 3-cycle: steps=%0d", steps - s0);

      do_reset(1'b0, 1'b0);
      s0 = steps;
      @(negedge clk); enc_a = 1'b1; enc_b = 1'b1;
      repeat (LAT + 3) @(negedge clk);
      chk("jump_err", err, 1);
      chk("jump_steps", steps - s0, 0);
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      chk("err_clr", err, 0);
      $display("jump 00->11: cleared err=%0d", err);
      drive(1'b0, 1'b1, "lat_after_err");
      @(negedge clk); enc_a = 1'b1; enc_b = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      chk("err_set_wins", err, 1);
      $display("jump 01->10 with err_clr: err=%0d", err);

      repeat (10) @(negedge clk);
      s0 = steps;
      enc_a = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_step", step, 0);
      chk("rst_mid_updown", updown, 1);
      chk("rst_mid_err", err, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      chk("rst_mid_steps", steps - s0, 0);
      $display("reset mid-transition: steps=%0d", steps - s0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
